// File: rtl/vend_credit_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// vend_credit_ctrl_pkg : shared state encodings, product ids, default prices
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vend_credit_ctrl_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CREDIT = 2'd1;
  localparam logic [1:0] ST_VEND   = 2'd2;
  localparam logic [1:0] ST_CHANGE = 2'd3;

  localparam int PROD_SNACK  = 0;
  localparam int PROD_COFFEE = 1;
  localparam int PROD_DRINK  = 2;
  localparam int PROD_CANDY  = 3;

  // id0 in the LSBs: snack=3, coffee=4, drink=4, candy=3 base units
  localparam logic [15:0] DEFAULT_PRICE_VEC = {4'd3, 4'd4, 4'd4, 4'd3};

endpackage

`default_nettype wire

// File: rtl/vend_price_lut.sv
// ---------------------------------------------------------------------------
// vend_price_lut : combinational product id -> price lookup with id-valid flag
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_price_lut
  import vend_credit_ctrl_pkg::*;
#(
  parameter int NUM_PROD = 4,
  parameter int SEL_W    = 2,
  parameter int CREDIT_W = 4,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_VEC = DEFAULT_PRICE_VEC
) (
  input  logic [SEL_W-1:0]    sel_id,
  output logic [CREDIT_W-1:0] price,
  output logic                id_valid
);

  // Ids beyond NUM_PROD fall through with id_valid low and a zero price.
  always_comb begin
    price    = '0;
    id_valid = 1'b0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (int'(sel_id) == i) begin
        price    = PRICE_VEC[i*CREDIT_W +: CREDIT_W];
        id_valid = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vend_credit_ctrl.sv
// ---------------------------------------------------------------------------
// vend_credit_ctrl : coin credit, pricing, cancel/refund and change payout
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vend_credit_ctrl
  import vend_credit_ctrl_pkg::*;
#(
  parameter int NUM_PROD   = 4,
  parameter int SEL_W      = 2,
  parameter int COIN_W     = 2,
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 5,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_VEC = DEFAULT_PRICE_VEC
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_id,
  input  logic                vend_ack,
  output logic                change_valid,
  input  logic                change_ready,
  output logic                coin_reject,
  output logic                sel_denied,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          state
);

  localparam int SUM_W = CREDIT_W + 1;

  logic [CREDIT_W-1:0] price;
  logic                price_valid;
  logic [SUM_W-1:0]    sum;
  logic                coin_ok;
  logic                sel_ok;

  vend_price_lut #(
    .NUM_PROD  (NUM_PROD),
    .SEL_W     (SEL_W),
    .CREDIT_W  (CREDIT_W),
    .PRICE_VEC (PRICE_VEC)
  ) u_price_lut (
    .sel_id   (sel_id),
    .price    (price),
    .id_valid (price_valid)
  );

  // One extra bit on the sum so an over-limit coin can never wrap into range.
  assign sum     = {1'b0, credit} + SUM_W'(coin_value);
  assign coin_ok = (coin_value != '0) && (sum <= SUM_W'(MAX_CREDIT));
  assign sel_ok  = price_valid && (credit >= price);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      credit       <= '0;
      vend_valid   <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      sel_denied   <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      sel_denied  <= 1'b0;
      case (state)
        ST_IDLE, ST_CREDIT: begin
          // cancel > sel > coin; every losing strobe is reported as refused
          if (cancel) begin
            coin_reject <= coin_valid;
            sel_denied  <= sel_valid;
            if (state == ST_CREDIT) begin
              state        <= ST_CHANGE;
              change_valid <= 1'b1;
            end
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (sel_ok) begin
              credit     <= credit - price;
              vend_id    <= sel_id;
              vend_valid <= 1'b1;
              state      <= ST_VEND;
            end else begin
              sel_denied <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_ok) begin
              credit <= sum[CREDIT_W-1:0];
              state  <= ST_CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          coin_reject <= coin_valid;
          sel_denied  <= sel_valid;
          if (vend_ack) begin
            vend_valid <= 1'b0;
            if (credit != '0) begin
              state        <= ST_CHANGE;
              change_valid <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: begin
          coin_reject <= coin_valid;
          sel_denied  <= sel_valid;
          // Last coin handshake drops change_valid and returns to IDLE together.
          if (change_valid && change_ready) begin
            credit <= credit - CREDIT_W'(1);
            if (credit == CREDIT_W'(1)) begin
              change_valid <= 1'b0;
              state        <= ST_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vend_credit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_credit_ctrl : directed and random checks against a behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vend_credit_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id = '0;
  logic       cancel = 1'b0;
  logic       vend_valid;
  logic [1:0] vend_id;
  logic       vend_ack = 1'b0;
  logic       change_valid;
  logic       change_ready = 1'b0;
  logic       coin_reject;
  logic       sel_denied;
  logic [3:0] credit;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Behavioural model: credit in units plus "busy vending"/"paying back" flags
  int prices[4] = '{3, 4, 4, 3};
  int m_credit  = 0;
  bit m_vend    = 0;
  bit m_refund  = 0;
  int m_vid     = 0;
  bit m_rej     = 0;
  bit m_den     = 0;

  vend_credit_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .coin_valid   (coin_valid),
    .coin_value   (coin_value),
    .sel_valid    (sel_valid),
    .sel_id       (sel_id),
    .cancel       (cancel),
    .vend_valid   (vend_valid),
    .vend_id      (vend_id),
    .vend_ack     (vend_ack),
    .change_valid (change_valid),
    .change_ready (change_ready),
    .coin_reject  (coin_reject),
    .sel_denied   (sel_denied),
    .credit       (credit),
    .state        (state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rs, input bit cv, input int cval, input bit sv,
                       input int sid, input bit cn, input bit ack, input bit rdy);
    m_rej = 0;
    m_den = 0;
    if (rs) begin
      m_credit = 0; m_vend = 0; m_refund = 0; m_vid = 0;
    end else if (m_vend) begin
      m_rej = cv; m_den = sv;
      if (ack) begin
        m_vend   = 0;
        m_refund = (m_credit > 0);
      end
    end else if (m_refund) begin
      m_rej = cv; m_den = sv;
      if (rdy) begin
        m_credit = m_credit - 1;
        if (m_credit == 0) m_refund = 0;
      end
    end else if (cn) begin
      m_rej = cv; m_den = sv;
      if (m_credit > 0) m_refund = 1;
    end else if (sv) begin
      m_rej = cv;
      if (sid < 4 && m_credit >= prices[sid]) begin
        m_credit = m_credit - prices[sid];
        m_vend   = 1;
        m_vid    = sid;
      end else begin
        m_den = 1;
      end
    end else if (cv) begin
      if (cval != 0 && m_credit + cval <= 5) m_credit = m_credit + cval;
      else m_rej = 1;
    end
  endtask

  function automatic int exp_state();
    if (m_vend)   return 2;
    if (m_refund) return 3;
    return (m_credit > 0) ? 1 : 0;
  endfunction

  // Apply one cycle of inputs, advance the model, and compare every output.
  task automatic step(input bit rs, input bit cv, input int cval, input bit sv,
                      input int sid, input bit cn, input bit ack, input bit rdy);
    reset = rs; coin_valid = cv; coin_value = 2'(cval);
    sel_valid = sv; sel_id = 2'(sid); cancel = cn;
    vend_ack = ack; change_ready = rdy;
    @(posedge clock);
    #1;
    model(rs, cv, cval, sv, sid, cn, ack, rdy);
    check("credit", 32'(credit), 32'(m_credit));
    check("state", 32'(state), 32'(exp_state()));
    check("vend_valid", 32'(vend_valid), 32'(m_vend));
    check("change_valid", 32'(change_valid), 32'(m_refund));
    check("coin_reject", 32'(coin_reject), 32'(m_rej));
    check("sel_denied", 32'(sel_denied), 32'(m_den));
    if (m_vend) check("vend_id", 32'(vend_id), 32'(m_vid));
    reset = 0; coin_valid = 0; sel_valid = 0; cancel = 0;
    vend_ack = 0; change_ready = 0;
  endtask

  task automatic idle_cycle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic coin(input int v);
    step(0, 1, v, 0, 0, 0, 0, 0);
  endtask

  task automatic sel(input int id);
    step(0, 0, 0, 1, id, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("rst_state", 32'(state), 0);
    check("rst_credit", 32'(credit), 0);
    check("rst_outputs", 32'({vend_valid, change_valid, coin_reject, sel_denied}), 0);

    // 1: three 10s then snack, ack with no change
    coin(1); check("t1_c1", 32'(credit), 1);
    coin(1); check("t1_c2", 32'(credit), 2);
    coin(1); check("t1_c3", 32'(credit), 3);
    sel(0);
    check("t1_vend", 32'({vend_valid, vend_id}), 32'({1'b1, 2'd0}));
    idle_cycle();
    check("t1_hold", 32'(vend_valid), 1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("t1_idle", 32'({state, change_valid}), 32'({2'd0, 1'b0}));

    // 2: 20+20, candy, one coin change
    coin(2); coin(2);
    check("t2_credit4", 32'(credit), 4);
    sel(3);
    check("t2_vend", 32'({vend_id, credit}), 32'({2'd3, 4'd1}));
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("t2_change", 32'({state, change_valid}), 32'({2'd3, 1'b1}));
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("t2_done", 32'({state, credit, change_valid}), 32'({2'd0, 4'd0, 1'b0}));

    // 3: coffee with only 30 credit
    coin(2); coin(1);
    sel(1);
    check("t3_denied", 32'({sel_denied, credit, state}), 32'({1'b1, 4'd3, 2'd1}));

    // 4: over-limit coin, then cancel with a stuttering change dispenser
    coin(1);
    coin(2);
    check("t4_reject", 32'({coin_reject, credit}), 32'({1'b1, 4'd4}));
    step(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, (i % 2 == 0));
    check("t4_done", 32'({state, credit, change_valid}), 32'({2'd0, 4'd0, 1'b0}));

    // 5: cancel+sel+coin together at credit 2
    coin(2);
    step(0, 1, 1, 1, 0, 1, 0, 0);
    check("t5_all", 32'({state, sel_denied, coin_reject, credit}),
          32'({2'd3, 1'b1, 1'b1, 4'd2}));
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    check("t5_idle", 32'(state), 0);

    // 6: reset during payout, then coin/cancel while vending
    coin(2); coin(1);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    check("t6_rst", 32'({state, credit, change_valid}), 32'({2'd0, 4'd0, 1'b0}));
    coin(2); coin(2);
    sel(1);
    step(0, 1, 1, 0, 0, 1, 0, 0);
    check("t6_vend", 32'({coin_reject, state, vend_valid}), 32'({1'b1, 2'd2, 1'b1}));
    step(0, 0, 0, 0, 0, 0, 1, 0);
    check("t6_idle", 32'(state), 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 2) == 0,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 4) == 0,
           int'($urandom_range(0, 3)),
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
